// File: rtl/vga_text_pkg.sv
// Shared definitions for the text-line renderer: letter codes, 17-segment numbering,
// theme colours and the segment geometry used by the pixel pipeline.
package vga_text_pkg;

    localparam int NUM_SEGS = 17;

    typedef enum logic [4:0] {
        L_A, L_B, L_C, L_D, L_E, L_F, L_G, L_H, L_I, L_J, L_K, L_L, L_M,
        L_N, L_O, L_P, L_Q, L_R, L_S, L_T, L_U, L_V, L_W, L_X, L_Y, L_Z,
        L_BLANK = 5'd31
    } letter_e;

    typedef enum logic [1:0] {
        TH_BW   = 2'b00,
        TH_WB   = 2'b01,
        TH_PINK = 2'b10,
        TH_ALT  = 2'b11
    } theme_e;

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_WHITE = 12'hfff;
    localparam logic [11:0] COL_PINK  = 12'he7d;

    localparam int SEG_TOP = 0;
    localparam int SEG_UR  = 1;
    localparam int SEG_LR  = 2;
    localparam int SEG_BOT = 3;
    localparam int SEG_LL  = 4;
    localparam int SEG_UL  = 5;
    localparam int SEG_ML  = 6;
    localparam int SEG_MR  = 7;
    localparam int SEG_CU  = 8;
    localparam int SEG_CD  = 9;
    localparam int SEG_DUL = 10;
    localparam int SEG_DUR = 11;
    localparam int SEG_DLL = 12;
    localparam int SEG_DLR = 13;
    localparam int SEG_SU  = 14;
    localparam int SEG_SD  = 15;
    localparam int SEG_DOT = 16;

    localparam logic [NUM_SEGS-1:0] M_TOP = NUM_SEGS'(1) << SEG_TOP;
    localparam logic [NUM_SEGS-1:0] M_UR  = NUM_SEGS'(1) << SEG_UR;
    localparam logic [NUM_SEGS-1:0] M_LR  = NUM_SEGS'(1) << SEG_LR;
    localparam logic [NUM_SEGS-1:0] M_BOT = NUM_SEGS'(1) << SEG_BOT;
    localparam logic [NUM_SEGS-1:0] M_LL  = NUM_SEGS'(1) << SEG_LL;
    localparam logic [NUM_SEGS-1:0] M_UL  = NUM_SEGS'(1) << SEG_UL;
    localparam logic [NUM_SEGS-1:0] M_ML  = NUM_SEGS'(1) << SEG_ML;
    localparam logic [NUM_SEGS-1:0] M_MR  = NUM_SEGS'(1) << SEG_MR;
    localparam logic [NUM_SEGS-1:0] M_CU  = NUM_SEGS'(1) << SEG_CU;
    localparam logic [NUM_SEGS-1:0] M_CD  = NUM_SEGS'(1) << SEG_CD;
    localparam logic [NUM_SEGS-1:0] M_DUL = NUM_SEGS'(1) << SEG_DUL;
    localparam logic [NUM_SEGS-1:0] M_DUR = NUM_SEGS'(1) << SEG_DUR;
    localparam logic [NUM_SEGS-1:0] M_DLL = NUM_SEGS'(1) << SEG_DLL;
    localparam logic [NUM_SEGS-1:0] M_DLR = NUM_SEGS'(1) << SEG_DLR;

    function automatic logic [11:0] theme_fg(input logic [1:0] th);
        return (th == TH_WB) ? COL_BLACK : COL_WHITE;
    endfunction

    function automatic logic [11:0] theme_bg(input logic [1:0] th);
        case (th)
            TH_WB:   return COL_WHITE;
            TH_PINK: return COL_PINK;
            default: return COL_BLACK;
        endcase
    endfunction

    // Which segments cover local pixel (lx,ly) of a w x h cell with stroke t.
    function automatic logic [NUM_SEGS-1:0] seg_hit(input int lx, input int ly,
                                                   input int w, input int h, input int t);
        logic [NUM_SEGS-1:0] s;
        int  hw, hh, qx, qy, d;
        logic left, upper, mid_band, ctr_col, diag;
        hw       = w / 2;
        hh       = h / 2;
        left     = (lx < hw);
        upper    = (ly < hh);
        mid_band = (ly >= hh - t / 2) && (ly < hh + t / 2);
        ctr_col  = (lx >= hw - t / 2) && (lx < hw + t / 2);
        // Diagonals run from each outer corner to the cell centre; mirror into the
        // upper-left quadrant so one stair-step test serves all four.
        qx   = left  ? lx : (w - 1) - lx;
        qy   = upper ? ly : (h - 1) - ly;
        d    = qx * h - qy * w;
        if (d < 0) d = -d;
        diag = (d < t * h);
        s          = '0;
        s[SEG_TOP] = (ly < t);
        s[SEG_UR]  = (lx >= w - t) && upper;
        s[SEG_LR]  = (lx >= w - t) && !upper;
        s[SEG_BOT] = (ly >= h - t);
        s[SEG_LL]  = (lx < t) && !upper;
        s[SEG_UL]  = (lx < t) && upper;
        s[SEG_ML]  = mid_band && left;
        s[SEG_MR]  = mid_band && !left;
        s[SEG_CU]  = ctr_col && upper;
        s[SEG_CD]  = ctr_col && !upper;
        s[SEG_DUL] = diag && left && upper;
        s[SEG_DUR] = diag && !left && upper;
        s[SEG_DLL] = diag && left && !upper;
        s[SEG_DLR] = diag && !left && !upper;
        s[SEG_SU]  = ctr_col && upper && (ly >= h / 4);
        s[SEG_SD]  = ctr_col && !upper && (ly < h - h / 4);
        s[SEG_DOT] = ctr_col && mid_band;
        return s;
    endfunction

endpackage

// File: rtl/vga_text_line_renderer_if.sv
// Buffer-write, frame control, scan coordinate and pixel output bundle of the renderer.
interface vga_text_line_renderer_if #(
    parameter int NUM_CHARS = 8
) ();
    logic                 wr_en_i;
    logic [3:0]           wr_idx_i;
    logic [4:0]           wr_letter_i;
    logic [1:0]           theme_i;
    logic [NUM_CHARS-1:0] blink_mask_i;
    logic                 frame_tick_i;
    logic [9:0]           h_cnt_i;
    logic [9:0]           v_cnt_i;
    logic                 valid_i;
    logic [11:0]          pixel_o;
    logic                 in_region_o;

    modport master (
        output wr_en_i, wr_idx_i, wr_letter_i, theme_i, blink_mask_i, frame_tick_i,
               h_cnt_i, v_cnt_i, valid_i,
        input  pixel_o, in_region_o
    );

    modport slave (
        input  wr_en_i, wr_idx_i, wr_letter_i, theme_i, blink_mask_i, frame_tick_i,
               h_cnt_i, v_cnt_i, valid_i,
        output pixel_o, in_region_o
    );
endinterface

// File: rtl/vga_glyph_rom.sv
// Letter code to 17-segment mask; codes outside A..Z light nothing.
module vga_glyph_rom
    import vga_text_pkg::*;
(
    input  logic [4:0]          letter_i,
    output logic [NUM_SEGS-1:0] mask_o
);

    always_comb begin
        mask_o = '0;
        case (letter_i)
            L_A: mask_o = M_TOP | M_UR | M_LR | M_LL | M_UL | M_ML | M_MR;
            L_B: mask_o = M_TOP | M_UR | M_LR | M_BOT | M_MR | M_CU | M_CD;
            L_C: mask_o = M_TOP | M_BOT | M_LL | M_UL;
            L_D: mask_o = M_TOP | M_UR | M_LR | M_BOT | M_CU | M_CD;
            L_E: mask_o = M_TOP | M_BOT | M_LL | M_UL | M_ML;
            L_F: mask_o = M_TOP | M_LL | M_UL | M_ML;
            L_G: mask_o = M_TOP | M_LR | M_BOT | M_LL | M_UL | M_MR;
            L_H: mask_o = M_UR | M_LR | M_LL | M_UL | M_ML | M_MR;
            L_I: mask_o = M_TOP | M_BOT | M_CU | M_CD;
            L_J: mask_o = M_UR | M_LR | M_BOT | M_LL;
            L_K: mask_o = M_LL | M_UL | M_ML | M_DUR | M_DLR;
            L_L: mask_o = M_BOT | M_LL | M_UL;
            L_M: mask_o = M_UR | M_LR | M_LL | M_UL | M_DUL | M_DUR;
            L_N: mask_o = M_UR | M_LR | M_LL | M_UL | M_DUL | M_DLR;
            L_O: mask_o = M_TOP | M_UR | M_LR | M_BOT | M_LL | M_UL;
            L_P: mask_o = M_TOP | M_UR | M_LL | M_UL | M_ML | M_MR;
            L_Q: mask_o = M_TOP | M_UR | M_LR | M_BOT | M_LL | M_UL | M_DLR;
            L_R: mask_o = M_TOP | M_UR | M_LL | M_UL | M_ML | M_MR | M_DLR;
            L_S: mask_o = M_TOP | M_LR | M_BOT | M_UL | M_ML | M_MR;
            L_T: mask_o = M_TOP | M_CU | M_CD;
            L_U: mask_o = M_UR | M_LR | M_BOT | M_LL | M_UL;
            L_V: mask_o = M_UL | M_LL | M_DLL | M_DUR;
            L_W: mask_o = M_UR | M_LR | M_LL | M_UL | M_DLL | M_DLR;
            L_X: mask_o = M_DUL | M_DUR | M_DLL | M_DLR;
            L_Y: mask_o = M_DUL | M_DUR | M_CD;
            L_Z: mask_o = M_TOP | M_BOT | M_DUR | M_DLL;
            default: mask_o = '0;
        endcase
    end

endmodule

// File: rtl/vga_text_line_renderer.sv
// Renders a line of 17-segment glyphs from a writable letter buffer into the pixel
// stream, two cycles behind the scan coordinate, with per-frame theme and blink.
module vga_text_line_renderer
    import vga_text_pkg::*;
#(
    parameter int NUM_CHARS    = 8,
    parameter int CHAR_W       = 32,
    parameter int CHAR_H       = 48,
    parameter int SEG_T        = 4,
    parameter int GAP          = 8,
    parameter int X0           = 64,
    parameter int Y0           = 200,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    vga_text_line_renderer_if.slave    bus
);

    localparam int PITCH = CHAR_W + GAP;
    localparam int SPAN  = NUM_CHARS * PITCH;
    localparam int LXW   = $clog2(PITCH);
    localparam int LYW   = $clog2(CHAR_H);
    localparam int BCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [4:0]           buf_q [NUM_CHARS];
    logic [1:0]           theme_q;
    logic [NUM_CHARS-1:0] blink_mask_q;
    logic [BCW-1:0]       blink_cnt_q;
    logic                 blink_phase_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CHARS; i++) buf_q[i] <= L_BLANK;
            theme_q       <= TH_BW;
            blink_mask_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            // Out-of-range slots match no entry and are silently dropped.
            for (int i = 0; i < NUM_CHARS; i++) begin
                if (bus.wr_en_i && (bus.wr_idx_i == 4'(i))) buf_q[i] <= bus.wr_letter_i;
            end
            if (bus.frame_tick_i) begin
                theme_q      <= bus.theme_i;
                blink_mask_q <= bus.blink_mask_i;
                if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BCW'(1);
                end
            end
        end
    end

    logic signed [10:0] dx, dy;
    logic [LXW-1:0]     lx_d;
    logic [LYW-1:0]     ly_d;
    logic [4:0]         letter_d;
    logic               blank_d;
    logic               hit_d;

    always_comb begin
        dx       = $signed({1'b0, bus.h_cnt_i}) - $signed(11'(X0));
        dy       = $signed({1'b0, bus.v_cnt_i}) - $signed(11'(Y0));
        lx_d     = dx[LXW-1:0];
        ly_d     = dy[LYW-1:0];
        letter_d = buf_q[0];
        blank_d  = blink_phase_q & blink_mask_q[0];
        // Cell select by comparing against each cell start; the low bits of the
        // difference are exact because the remainder is always below PITCH.
        for (int i = 1; i < NUM_CHARS; i++) begin
            if (dx >= $signed(11'(i * PITCH))) begin
                lx_d     = dx[LXW-1:0] - LXW'(i * PITCH);
                letter_d = buf_q[i];
                blank_d  = blink_phase_q & blink_mask_q[i];
            end
        end
        hit_d = bus.valid_i
              && (dy >= 11'sd0) && (dy < $signed(11'(CHAR_H)))
              && (dx >= 11'sd0) && (dx < $signed(11'(SPAN)))
              && ({1'b0, lx_d} < (LXW + 1)'(CHAR_W));
    end

    logic           s1_valid_q;
    logic           s1_hit_q;
    logic [LXW-1:0] s1_lx_q;
    logic [LYW-1:0] s1_ly_q;
    logic [4:0]     s1_letter_q;
    logic           s1_blank_q;
    logic [11:0]    pixel_q;
    logic           in_region_q;

    logic [NUM_SEGS-1:0] glyph_mask;
    logic [NUM_SEGS-1:0] seg_cov;
    logic                fg_d;
    logic [11:0]         pixel_d;

    vga_glyph_rom u_rom (
        .letter_i (s1_letter_q),
        .mask_o   (glyph_mask)
    );

    always_comb begin
        seg_cov = seg_hit(int'(s1_lx_q), int'(s1_ly_q), CHAR_W, CHAR_H, SEG_T);
        fg_d    = s1_hit_q & (|(glyph_mask & seg_cov)) & ~s1_blank_q;
        if (!s1_valid_q)  pixel_d = COL_BLACK;
        else if (fg_d)    pixel_d = theme_fg(theme_q);
        else              pixel_d = theme_bg(theme_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_lx_q     <= '0;
            s1_ly_q     <= '0;
            s1_letter_q <= '0;
            s1_blank_q  <= 1'b0;
            pixel_q     <= '0;
            in_region_q <= 1'b0;
        end else begin
            s1_valid_q  <= bus.valid_i;
            s1_hit_q    <= hit_d;
            s1_lx_q     <= lx_d;
            s1_ly_q     <= ly_d;
            s1_letter_q <= letter_d;
            s1_blank_q  <= blank_d;
            pixel_q     <= pixel_d;
            in_region_q <= s1_hit_q;
        end
    end

    assign bus.pixel_o     = pixel_q;
    assign bus.in_region_o = in_region_q;

endmodule

// File: tb/tb_vga_text_line_renderer.sv
// Scoreboard bench: each driven scan coordinate queues its hand-derived pixel and
// in_region, checked when the pipeline delivers it two cycles later.
module tb_vga_text_line_renderer;

    localparam int NC    = 8;
    localparam int X0    = 64;
    localparam int Y0    = 200;
    localparam int PITCH = 40;
    localparam int BF    = 2;
    localparam logic [11:0] BLK = 12'h000;
    localparam logic [11:0] WHT = 12'hfff;
    localparam logic [11:0] PNK = 12'he7d;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        int          due;
        logic [11:0] pix;
        logic        reg_;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int   m_cnt = 0;
    logic m_phase = 1'b0;
    logic m_mask = 1'b0;

    vga_text_line_renderer_if #(.NUM_CHARS(NC)) bus ();

    vga_text_line_renderer #(
        .NUM_CHARS(NC), .CHAR_W(32), .CHAR_H(48), .SEG_T(4), .GAP(8),
        .X0(X0), .Y0(Y0), .BLINK_FRAMES(BF)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial forever #20 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due == cycle_cnt) begin
            mon_e = sb.pop_front();
            n_tests++;
            if (bus.pixel_o !== mon_e.pix || bus.in_region_o !== mon_e.reg_) begin
                n_fail++;
                $display("FAIL %s: pixel=%h in_region=%b, expected pixel=%h in_region=%b",
                         mon_e.tag, bus.pixel_o, bus.in_region_o, mon_e.pix, mon_e.reg_);
            end
        end
    end

    task automatic drive(input int x, input int y, input logic vld, input logic [11:0] ep,
                         input logic er, input string tag, input logic r = 1'b0);
        exp_t e;
        bus.h_cnt_i = 10'(x);
        bus.v_cnt_i = 10'(y);
        bus.valid_i = vld;
        rst         = r;
        e.due  = cycle_cnt + 2;
        e.pix  = ep;
        e.reg_ = er;
        e.tag  = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic write_slot(input int idx, input int letter);
        bus.wr_en_i     = 1'b1;
        bus.wr_idx_i    = 4'(idx);
        bus.wr_letter_i = 5'(letter);
        @(negedge clk);
        bus.wr_en_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d outputs outstanding, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic tick();
        bus.valid_i      = 1'b0;
        bus.frame_tick_i = 1'b1;
        @(negedge clk);
        bus.frame_tick_i = 1'b0;
        m_mask = bus.blink_mask_i[0];
        m_cnt++;
        if (m_cnt == BF) begin
            m_cnt   = 0;
            m_phase = ~m_phase;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.pixel_o !== BLK || bus.in_region_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: pixel=%h in_region=%b, expected pixel=000 in_region=0",
                     bus.pixel_o, bus.in_region_o);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int ly = 0; ly < 48; ly += 7)
            for (int lx = 0; lx < 32; lx += 5)
                drive(X0 + lx, Y0 + ly, 1'b1, BLK, 1'b1, "blank_cell");
        drive(X0 + 31, Y0 + 47, 1'b1, BLK, 1'b1, "blank_corner");
        drain("reset");
    endtask

    task automatic test_glyph();
        write_slot(0, 19);
        drive(X0 + 16, Y0 + 1,  1'b1, WHT, 1'b1, "t_top");
        drive(X0 + 1,  Y0 + 24, 1'b1, BLK, 1'b1, "t_bg");
        drive(X0 + 15, Y0 + 30, 1'b1, WHT, 1'b1, "t_stem");
        drain("glyph");
    endtask

    task automatic test_theme();
        bus.theme_i = 2'b01;
        drive(X0 + 16, Y0 + 1,  1'b1, WHT, 1'b1, "theme_hold_fg");
        drive(X0 + 1,  Y0 + 24, 1'b1, BLK, 1'b1, "theme_hold_bg");
        drain("theme_hold");
        tick();
        drive(X0 + 16, Y0 + 1,  1'b1, BLK, 1'b1, "theme01_fg");
        drive(X0 + 1,  Y0 + 24, 1'b1, WHT, 1'b1, "theme01_bg");
        drive(X0 - 10, Y0 + 5,  1'b1, WHT, 1'b0, "theme01_outside");
        drive(X0 + 16, Y0 + 1,  1'b0, BLK, 1'b0, "invalid");
        drain("theme");
    endtask

    task automatic test_blink();
        write_slot(1, 19);
        bus.blink_mask_i = 8'h01;
        bus.theme_i      = 2'b10;
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(X0 + 16, Y0 + 1, 1'b1, (m_mask && m_phase) ? PNK : WHT, 1'b1, "blink_cell0");
            drive(X0 + 1, Y0 + 24, 1'b1, PNK, 1'b1, "blink_bg0");
            drive(X0 + PITCH + 16, Y0 + 1, 1'b1, WHT, 1'b1, "blink_cell1");
            drain("blink");
            tick();
        end
        bus.blink_mask_i = 8'h00;
        bus.theme_i      = 2'b11;
        tick();
        drive(X0 + 16, Y0 + 1,  1'b1, WHT, 1'b1, "theme11_fg");
        drive(X0 + 1,  Y0 + 24, 1'b1, BLK, 1'b1, "theme11_bg");
        drain("blink_end");
    endtask

    task automatic test_write_rules();
        write_slot(NC, 31);
        write_slot(15, 31);
        drive(X0 + 16, Y0 + 1, 1'b1, WHT, 1'b1, "wr_oob");
        bus.wr_en_i     = 1'b1;
        bus.wr_idx_i    = 4'd3;
        bus.wr_letter_i = 5'd19;
        drive(X0 + 3 * PITCH + 16, Y0 + 1, 1'b1, BLK, 1'b1, "wr_same_cycle");
        bus.wr_en_i = 1'b0;
        drive(X0 + 3 * PITCH + 16, Y0 + 1, 1'b1, WHT, 1'b1, "wr_after");
        write_slot(2, 27);
        drive(X0 + 2 * PITCH + 16, Y0 + 1, 1'b1, BLK, 1'b1, "unknown_code");
        write_slot(4, 0);
        drive(X0 + 4 * PITCH + 1,  Y0 + 30, 1'b1, WHT, 1'b1, "a_left");
        drive(X0 + 4 * PITCH + 16, Y0 + 30, 1'b1, BLK, 1'b1, "a_centre");
        write_slot(5, 23);
        drive(X0 + 5 * PITCH + 8, Y0 + 12, 1'b1, WHT, 1'b1, "x_diag");
        drive(X0 + 5 * PITCH + 8, Y0 + 20, 1'b1, BLK, 1'b1, "x_off");
        drain("write");
    endtask

    task automatic test_region_and_reset();
        bus.theme_i = 2'b10;
        tick();
        drive(X0 + 34, Y0 + 5, 1'b1, PNK, 1'b0, "gap");
        drive(X0 + 32, Y0 + 5, 1'b1, PNK, 1'b0, "gap_edge");
        drive(X0 + PITCH, Y0, 1'b1, WHT, 1'b1, "cell1_edge");
        drive(X0 - 1, Y0 + 5, 1'b1, PNK, 1'b0, "left_of_x0");
        drive(X0 + 7 * PITCH + 31, Y0 + 47, 1'b1, PNK, 1'b1, "last_cell");
        drive(X0 + NC * PITCH, Y0 + 5, 1'b1, PNK, 1'b0, "past_end");
        drive(X0 + 16, Y0 - 1,  1'b1, PNK, 1'b0, "above");
        drive(X0 + 16, Y0 + 48, 1'b1, PNK, 1'b0, "below");
        drive(X0 + 16, Y0 + 1, 1'b1, WHT, 1'b1, "pre_rst");
        drive(X0 + 16, Y0 + 1, 1'b1, BLK, 1'b0, "rst_flush_s2");
        drive(X0 + 16, Y0 + 1, 1'b1, BLK, 1'b0, "rst_flush_s1", 1'b1);
        drive(X0 + 16, Y0 + 1, 1'b1, BLK, 1'b1, "post_rst");
        drain("region");
    endtask

    initial begin
        bus.wr_en_i      = 1'b0;
        bus.wr_idx_i     = '0;
        bus.wr_letter_i  = '0;
        bus.theme_i      = 2'b00;
        bus.blink_mask_i = '0;
        bus.frame_tick_i = 1'b0;
        bus.h_cnt_i      = '0;
        bus.v_cnt_i      = '0;
        bus.valid_i      = 1'b0;
        @(negedge clk);
        test_reset();
        test_glyph();
        test_theme();
        test_blink();
        test_write_rules();
        test_region_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
